// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the returned instruction into IF/ID with its PC, valid bit and fetch count.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  input  logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] addr,
  output logic [INST_W-1:0] ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      // Memory data for the current PC is not settled yet, so nothing is captured.
      StBoot: begin
        valid_d = 1'b0;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StRun;
        end else if (halt_req) begin
          state_d = StHalted;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (halt_req) begin
          valid_d = 1'b0;
          state_d = StHalted;
        end else if (!stall) begin
          inst_d  = inst;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHalted: begin
        valid_d = 1'b0;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StBoot;
        end
      end
      default: begin
        state_d = StBoot;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr        = pc_q;
  assign ifid_inst   = inst_q;
  assign ifid_pc     = ipc_q;
  assign ifid_valid  = valid_q;
  assign halted      = (state_q == StHalted);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus hand-written
// sequences for asynchronous reset and fetch-count saturation.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic        halt_req = 1'b0;
  logic [31:0] inst = 32'd0;
  logic [7:0]  addr;
  logic [31:0] ifid_inst;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  s_addr;
  logic [31:0] s_inst;
  logic [7:0]  s_pc;
  logic        s_valid;
  logic        s_halted;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .inst(inst), .addr(addr), .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  // Narrow counter copy, used only to observe saturation.
  fetch_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .inst(inst), .addr(s_addr), .ifid_inst(s_inst),
    .ifid_pc(s_pc), .ifid_valid(s_valid), .halted(s_halted), .fetch_count(s_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: returns A000_0000 | addr, updated on the falling edge.
  always @(negedge clk) inst = 32'hA000_0000 | {24'd0, addr};

  typedef struct {
    logic        stall;
    logic        redir;
    logic [7:0]  rpc;
    logic        halt;
    logic [7:0]  e_addr;
    logic [31:0] e_inst;
    logic [7:0]  e_pc;
    logic        e_valid;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic [7:0] rp, logic h, logic [7:0] ea,
                              logic [31:0] ei, logic [7:0] ep, logic ev, logic eh,
                              logic [15:0] ec);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.halt = h;
    v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_valid = ev; v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ea, input logic [31:0] ei,
                           input logic [7:0] ep, input logic ev, input logic eh,
                           input logic [15:0] ec);
    check({tag, " addr"}, {24'd0, addr}, {24'd0, ea});
    check({tag, " ifid_inst"}, ifid_inst, ei);
    check({tag, " ifid_pc"}, {24'd0, ifid_pc}, {24'd0, ep});
    check({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, ev});
    check({tag, " halted"}, {31'd0, halted}, {31'd0, eh});
    check({tag, " fetch_count"}, {16'd0, fetch_count}, {16'd0, ec});
  endtask

  localparam logic [31:0] A = 32'hA000_0000;

  initial begin
    // Stall 3 cycles at pc=5; redirect to 150 at pc=10; stalled redirect; wrap via 254;
    // halt at pc=20 with stall toggling; redirect out of halt to 200 through boot;
    // simultaneous redirect and halt.
    vecs.push_back(mk(0, 0, 0,   0, 8'd0,   32'd0,  8'd0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0, 8'd1,   A|0,    8'd0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0,   0, 8'd2,   A|1,    8'd1,   1, 0, 2));
    vecs.push_back(mk(0, 0, 0,   0, 8'd3,   A|2,    8'd2,   1, 0, 3));
    vecs.push_back(mk(0, 0, 0,   0, 8'd4,   A|3,    8'd3,   1, 0, 4));
    vecs.push_back(mk(0, 0, 0,   0, 8'd5,   A|4,    8'd4,   1, 0, 5));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 8'd5, A|4, 8'd4, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0,   0, 8'd6,   A|5,    8'd5,   1, 0, 6));
    vecs.push_back(mk(0, 0, 0,   0, 8'd7,   A|6,    8'd6,   1, 0, 7));
    vecs.push_back(mk(0, 0, 0,   0, 8'd8,   A|7,    8'd7,   1, 0, 8));
    vecs.push_back(mk(0, 0, 0,   0, 8'd9,   A|8,    8'd8,   1, 0, 9));
    vecs.push_back(mk(0, 0, 0,   0, 8'd10,  A|9,    8'd9,   1, 0, 10));
    vecs.push_back(mk(0, 1, 150, 0, 8'd150, A|9,    8'd9,   0, 0, 10));
    vecs.push_back(mk(0, 0, 0,   0, 8'd151, A|150,  8'd150, 1, 0, 11));
    vecs.push_back(mk(0, 0, 0,   0, 8'd152, A|151,  8'd151, 1, 0, 12));
    vecs.push_back(mk(1, 1, 150, 0, 8'd150, A|151,  8'd151, 0, 0, 12));
    vecs.push_back(mk(0, 0, 0,   0, 8'd151, A|150,  8'd150, 1, 0, 13));
    vecs.push_back(mk(0, 1, 254, 0, 8'd254, A|150,  8'd150, 0, 0, 13));
    vecs.push_back(mk(0, 0, 0,   0, 8'd255, A|254,  8'd254, 1, 0, 14));
    vecs.push_back(mk(0, 0, 0,   0, 8'd0,   A|255,  8'd255, 1, 0, 15));
    vecs.push_back(mk(0, 0, 0,   0, 8'd1,   A|0,    8'd0,   1, 0, 16));
    vecs.push_back(mk(0, 1, 19,  0, 8'd19,  A|0,    8'd0,   0, 0, 16));
    vecs.push_back(mk(0, 0, 0,   0, 8'd20,  A|19,   8'd19,  1, 0, 17));
    vecs.push_back(mk(0, 0, 0,   1, 8'd20,  A|19,   8'd19,  0, 1, 17));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(i[0], 0, 0, 0, 8'd20, A|19, 8'd19, 0, 1, 17));
    vecs.push_back(mk(0, 1, 200, 0, 8'd200, A|19,   8'd19,  0, 0, 17));
    vecs.push_back(mk(0, 0, 0,   0, 8'd200, A|19,   8'd19,  0, 0, 17));
    vecs.push_back(mk(0, 0, 0,   0, 8'd201, A|200,  8'd200, 1, 0, 18));
    vecs.push_back(mk(0, 1, 5,   1, 8'd5,   A|200,  8'd200, 0, 0, 18));
    vecs.push_back(mk(0, 0, 0,   0, 8'd6,   A|5,    8'd5,   1, 0, 19));

    repeat (2) @(posedge clk);
    #1 check_all("reset", 8'd0, 32'd0, 8'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; halt_req = vecs[i].halt;
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc,
                   vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_cnt);
      @(negedge clk);
    end

    check("sat fetch_count", {29'd0, s_count}, 32'd7);

    // Async reset between edges while a stalled redirect is pending.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'd77; halt_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all("async rst", 8'd0, 32'd0, 8'd0, 1'b0, 1'b0, 16'd0);
    check("async rst sat count", {29'd0, s_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
    @(posedge clk);
    #1 check_all("reboot", 8'd0, 32'd0, 8'd0, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1 check_all("refetch0", 8'd1, A|0, 8'd0, 1'b1, 1'b0, 16'd1);
    @(posedge clk);
    #1 check_all("refetch1", 8'd2, A|1, 8'd1, 1'b1, 1'b0, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
